// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive/transmit blocks.
// The parity state exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Receiver FSM states; encodings are fixed so the debug port is stable
  // across builds with and without parity.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_rx_state_t;

  // Clock cycles per oversample tick; never less than 1.
  function automatic int calc_div(input longint clk_freq, input longint baud,
                                  input int oversample);
    longint d;
    d = clk_freq / (baud * longint'(oversample));
    if (d < 1) d = 1;
    return int'(d);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 0..DIV-1 counter producing a one-cycle tick
// on its last count. A synchronous clear restarts the count at 0 so the
// first tick after release lands DIV cycles later.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Divisor counter: held at 0 while cleared, wraps after LAST.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling UART receiver (8N1, or 8E1 when
// UART_RX_PARITY_EN is defined) feeding a one-deep holding register.
//
// Handshake: o_valid high means o_data holds a byte and o_data stays stable
// until the cycle where o_valid && i_ready; o_valid drops on the following
// cycle unless a new byte loads on that same edge. i_ready may be driven
// freely and has no effect while o_valid is low.
`timescale 1ns/1ps
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy,
  output logic [2:0]           o_dbg_state
);

  localparam int            DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int            SW        = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_ONE  = SW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  // Synchronizer and edge history.
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_fall;

  // FSM.
  uart_rx_state_t r_state;
  uart_rx_state_t w_state_next;

  // Bit timing and sampling.
  logic                 w_tick;
  logic [SW-1:0]        r_samp;
  logic [2:0]           r_bit;
  logic                 r_s0;
  logic                 r_s1;
  logic                 w_maj;
  logic                 w_resolve;
  logic                 w_bit_end;
  logic [DATA_BITS-1:0] r_shift;

  // Frame outcome.
  logic w_stop_done;
  logic w_par_err;

  // Holding register and registered pulses.
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  // Two-flop synchronizer plus one history flop; all idle high after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // A start needs a real 1->0 transition; a line already low never counts.
  assign w_fall = r_prev && !r_sync2;

  // Tick divider is held cleared in IDLE, so it restarts at every start edge.
  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (r_state == ST_IDLE),
    .o_tick  (w_tick)
  );

  assign w_maj       = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign w_resolve   = w_tick && (r_samp == SAMP_C);
  assign w_bit_end   = w_tick && (r_samp == SAMP_LAST);
  assign w_stop_done = (r_state == ST_STOP) && w_resolve;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_next = ST_START;
      end
      ST_START: begin
        if (w_resolve && w_maj) begin
          w_state_next = ST_IDLE;
        end else if (w_bit_end) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = ST_PARITY;
`else
          w_state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_resolve) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sample/bit counters, majority samples and the data shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp  <= '0;
      r_bit   <= '0;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_shift <= '0;
    end else if (r_state == ST_IDLE) begin
      r_samp <= '0;
      r_bit  <= '0;
    end else if (w_tick) begin
      r_samp <= (r_samp == SAMP_LAST) ? '0 : r_samp + SAMP_ONE;
      if (r_samp == SAMP_A) r_s0 <= r_sync2;
      if (r_samp == SAMP_B) r_s1 <= r_sync2;
      if (w_resolve && (r_state == ST_DATA)) begin
        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      end
      if (w_bit_end && (r_state == ST_DATA)) begin
        r_bit <= r_bit + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  // Captured parity bit; even parity means data plus parity has no odd 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_bit <= 1'b0;
    end else if ((r_state == ST_PARITY) && w_resolve) begin
      r_par_bit <= w_maj;
    end
  end

  assign w_par_err = ^{r_shift, r_par_bit};

  // Parity error pulse, issued when the stop bit resolves.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_stop_done && w_par_err;
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign w_par_err    = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  // Holding register, framing and overrun pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_done && !w_maj;
      r_overrun   <= 1'b0;
      if (r_valid && i_ready) r_valid <= 1'b0;
      if (w_stop_done && w_maj && !w_par_err) begin
        // A byte consumed on this edge frees the register for the new one.
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Upstream receive stage for the serial encryption path. Converts the raw asynchronous UART line from the host into validated 8-bit bytes and presents them through a one-deep holding register with a valid/ready handshake. It feeds the encrypter's byte input. The encrypter consumes one byte per handshake, and this block reports framing, parity and overrun errors.

## Interface
- CLK_FREQ, 100_000_000: i_clk frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: sample ticks per bit. Must be ≥ 8 and even.
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_uart_rx  in  1  raw serial line. Idle high, 8N1 (8E1 with parity enabled), LSB first.
- o_data  out  8  received byte. Stable while o_valid is high.
- o_valid  out  1  holding register full.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- o_overrun  out  1  one-cycle pulse: a complete byte was dropped because the holding register was full.
- o_busy  out  1  high from start-bit detection until the FSM returns to IDLE.

## Operation
- Input synchronizer: 2-flop, reset to 1. Start detection uses the synchronized line and its previous value.
- Tick divisor DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division. The default is 54.
- Tick counter: runs 0..DIV-1. It is cleared on start detection so the first tick lands DIV cycles later.
- Sample counter: runs 0..OVERSAMPLE-1 within each bit.
- Bit value: majority of the three samples at sample counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit is resolved at OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE→START: falling edge (prev 1, now 0). A line that is already low never triggers a start.
  - START: majority 1 at mid-bit is a false start and returns to IDLE with no outputs. Majority 0 goes to DATA at the end of the bit.
  - DATA: shifts in 8 bits LSB first. Moves to PARITY or STOP after bit 7.
  - PARITY: captures the parity bit.
  - STOP: resolves the stop bit at mid-bit and returns to IDLE in the same cycle. The remaining half bit is not waited out.
- Stop resolved 1 with no parity error:
  - Holding register empty, or emptied this same cycle by a handshake: load the byte and set o_valid.
  - Otherwise: drop the byte, pulse o_overrun, keep the old o_data/o_valid.
- Stop resolved 0: pulse o_frame_err and discard the byte. A break (line held low) produces exactly one frame error, then waits for a rising and then a falling edge.
- o_valid clears on the cycle after o_valid && i_ready.
- Reset values (any time, including mid-byte): FSM=IDLE, counters=0, o_data=0, o_valid=0, all error pulses 0, o_busy=0, synchronizer=1. Any partial byte is discarded.

## Timing
- Start detection: 2 cycles after the line falls.
- o_valid rises 1 cycle after the stop-bit resolve tick. That is about 9.5 bit times plus 3 cycles after the line falls (10.5 bit times with parity).
- Error pulses are exactly 1 cycle wide, registered, and issued in the same cycle o_valid would have risen.
- A handshake and a new byte completing in the same cycle: the handshake consumes the old byte, the new byte loads, and o_valid stays high.
- Back-to-back frames are accepted with no idle gap. The next start edge is detectable immediately after STOP resolves.

## Configuration
- UART_RX_PARITY_EN defined:
  - Adds the PARITY state and expects even parity after bit 7.
  - On mismatch, pulses o_parity_err and drops the byte, even if the stop bit is good. A bad stop bit also pulses o_frame_err.
- UART_RX_PARITY_EN undefined:
  - 8N1 only, with no PARITY state.
  - o_parity_err is held at 0.

## Structure
- Package uart_pkg: FSM state enum, DATA_BITS=8, default OVERSAMPLE, and a function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module uart_baud_tick: DIV counter with a synchronous clear and a one-cycle tick output. It is reusable by the transmit side.

## Test plan
- Send 0xA5 at 115200 with i_ready held high → o_data=0xA5, o_valid high for 1 cycle, no error pulses.
- Send 0x3C with i_ready low for 2000 cycles → o_valid and o_data=0x3C held stable until i_ready rises, then o_valid drops the next cycle.
- Send 0x12 then 0x34 back-to-back with i_ready low → o_data stays 0x12, one o_overrun pulse, o_valid stays high.
- Drive a 3-cycle low glitch on an idle line → o_busy returns low within 1 bit time, no o_valid, no errors.
- Send 0x55 with the stop bit low → one o_frame_err pulse, no o_valid. Then send 0x0F normally → 0x0F received.
- Assert i_rst_n low mid-DATA of 0xFF, release, then send 0x81 → only 0x81 received.
- With UART_RX_PARITY_EN, send 0x07 with an odd parity bit → one o_parity_err pulse, no o_valid.
